ecdsa_sign_finalize: RTL and testbench
======================================

// Module: ecdsa_sign_finalize
// PURPOSE
//  Consumes the x-coordinate of kG from double_and_add and produces the ECDSA
//  signature pair: r = x mod q, s = kinv*(z + r*d) mod q.
//  Sequential, bit-serial interleaved modular multiplier with start/busy/done
//  handshake. kinv is supplied by the upstream nonce-inverse stage.
// PARAMETERS
//  n   256   operand width in bits. q must satisfy 2^(n-1) < q < 2^n.
// PORTS
//  clk    in   1  clock; all state updates on posedge
//  reset  in   1  asynchronous, active-high; clears all state and outputs
//  start  in   1  request; sampled only in IDLE
//  x3     in   n  affine x of kG from double_and_add (x3 < p, p < 2q)
//  q      in   n  group order
//  z      in   n  message hash, truncated to n bits (may be >= q)
//  d      in   n  private key, d < q
//  kinv   in   n  k^-1 mod q, kinv < q
//  r      out  n  signature r
//  s      out  n  signature s
//  busy   out  1  high from the edge accepting start until done
//  done   out  1  one-cycle pulse when r/s/err are valid
//  err    out  1  r==0 or s==0; valid with done
// BEHAVIOUR
//  Reset (async): r=s=0, busy=done=err=0, state IDLE, bit counter 0.
//  Inputs latched on the start edge; later input changes have no effect.
//  FSM: IDLE -> RED -> MUL1 -> ADDZ -> MUL2 -> CHECK -> DONE -> IDLE.
//   IDLE : start=1 -> latch inputs, busy=1, go RED. start ignored in other states.
//   RED  : 1 cycle. rr = (x3>=q)?x3-q:x3; zz = (z>=q)?z-q:z.
//   MUL1 : n cycles, MSB-first over d: acc=2*acc mod q; if d[i] acc=acc+rr mod q.
//          Each step at most one conditional subtract; intermediates n+1 bits.
//   ADDZ : 1 cycle. t = acc+zz; if t>=q t-=q. acc cleared.
//   MUL2 : n cycles, same datapath, multiplicand t, multiplier bits of kinv.
//   CHECK: 1 cycle. optional low-S fold (see CONFIGURATION).
//   DONE : r<=rr, s<=result, err<=(rr==0)|(result==0), done=1 for 1 cycle,
//          busy deasserts on the same edge; next edge returns to IDLE.
//  Latency: done high exactly 2n+4 edges after the edge that sampled start.
//  start high during DONE not accepted; accepted in the IDLE cycle that follows.
//  r, s, err hold their values until the next DONE; err updated only in DONE.
//  Edge cases: x3==q -> r=0, err=1, s computed anyway. z in [q,2^n) reduced
//   once. d=0 -> acc=0 after MUL1. kinv=0 -> s=0, err=1.
//  Reset mid-operation: immediate abort, all outputs to reset values, no done.
//  Out-of-range d/kinv (>= q): result undefined; no check performed.
// CONFIGURATION
//  ECDSA_LOW_S_EN defined: in CHECK, if result > (q>>1) then result = q-result
//   (canonical low-S form); adds one n-bit compare and subtract, no extra cycle.
//  Not defined: CHECK passes result through unchanged; latency identical.
// TESTING
//  (n=8, q=251 unless stated)
//  T1 x3=7,d=5,z=20,kinv=3 -> r=7, s=165 (86 with ECDSA_LOW_S_EN), err=0,
//     done exactly 20 edges after start.
//  T2 x3=251,d=5,z=20,kinv=3 -> r=0, err=1; x3=255 -> r=4, s=3*(20+20)%251=120.
//  T3 x3=7,d=5,z=216,kinv=3 -> s=0, err=1; z=255 treated as 4: s=3*39%251=117.
//  T4 assert reset during MUL1 cycle 3 -> r=s=0, busy=done=err=0 asynchronously;
//     fresh T1 run afterwards gives identical T1 results.
//  T5 hold start high for 40 cycles -> exactly two done pulses, 21 edges apart;
//     input changes while busy do not affect r/s.
//  T6 n=256, secp256k1 q, 1000 random (x3<p, z, d<q, kinv<q) vs software
//     model -> all r/s/err match, both with and without ECDSA_LOW_S_EN.

Source files
------------

// File: rtl/ecdsa_sign_finalize.sv
// ecdsa_sign_finalize: builds the ECDSA signature pair from the x-coordinate of kG.
//   r = x3 mod q
//   s = kinv * (z + r*d) mod q
// A single bit-serial, MSB-first interleaved modular multiplier is used twice:
// first for r*d, then for kinv*t.
// Optional feature: define ECDSA_LOW_S_EN to fold s into canonical low-S form,
// so that s <= q>>1. The fold happens inside the CHECK cycle, so the latency
// does not change.
module ecdsa_sign_finalize #(
  parameter int n = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] x3,
  input  logic [n-1:0] q,
  input  logic [n-1:0] z,
  input  logic [n-1:0] d,
  input  logic [n-1:0] kinv,
  output logic [n-1:0] r,
  output logic [n-1:0] s,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RED   = 3'd1,
    MUL1  = 3'd2,
    ADDZ  = 3'd3,
    MUL2  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state_r;
  logic [n-1:0]  x3_r;
  logic [n-1:0]  q_r;
  logic [n-1:0]  z_r;
  logic [n-1:0]  kinv_r;
  logic [n-1:0]  mul_r;    // multiplier bits, shifted out MSB-first
  logic [n-1:0]  mcand_r;  // multiplicand: rr in MUL1, t in MUL2
  logic [n-1:0]  rr_r;
  logic [n-1:0]  zz_r;
  logic [n-1:0]  acc_r;
  logic [n-1:0]  res_r;
  logic [CW-1:0] cnt_r;

  logic [n-1:0]  rr_s;
  logic [n-1:0]  zz_s;
  logic [n-1:0]  dbl_s;
  logic [n-1:0]  step_s;
  logic [n-1:0]  addz_s;
  logic [n-1:0]  fold_s;

  // (a + b) mod m for a, b < m; the sum is kept n+1 bits wide so it cannot
  // overflow, and at most one conditional subtract is needed.
  function automatic logic [n-1:0] mod_add(input logic [n-1:0] a,
                                           input logic [n-1:0] b,
                                           input logic [n-1:0] m);
    logic [n:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) begin
      sum = sum - {1'b0, m};
    end else begin
      sum = sum;
    end
    return sum[n-1:0];
  endfunction

  // Datapath: single-subtract reductions and one multiplier step.
  always_comb begin
    rr_s   = x3_r;
    zz_s   = z_r;
    dbl_s  = '0;
    step_s = '0;
    addz_s = '0;
    fold_s = acc_r;
    if (x3_r >= q_r) begin
      rr_s = x3_r - q_r;
    end else begin
      rr_s = x3_r;
    end
    if (z_r >= q_r) begin
      zz_s = z_r - q_r;
    end else begin
      zz_s = z_r;
    end
    dbl_s = mod_add(acc_r, acc_r, q_r);
    if (mul_r[n-1]) begin
      step_s = mod_add(dbl_s, mcand_r, q_r);
    end else begin
      step_s = dbl_s;
    end
    addz_s = mod_add(acc_r, zz_r, q_r);
`ifdef ECDSA_LOW_S_EN
    if (acc_r > (q_r >> 1)) begin
      fold_s = q_r - acc_r;
    end else begin
      fold_s = acc_r;
    end
`else
    fold_s = acc_r;
`endif
  end

  // Control FSM, operand registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      x3_r    <= '0;
      q_r     <= '0;
      z_r     <= '0;
      kinv_r  <= '0;
      mul_r   <= '0;
      mcand_r <= '0;
      rr_r    <= '0;
      zz_r    <= '0;
      acc_r   <= '0;
      res_r   <= '0;
      cnt_r   <= '0;
      r       <= '0;
      s       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            x3_r    <= x3;
            q_r     <= q;
            z_r     <= z;
            mul_r   <= d;
            kinv_r  <= kinv;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RED;
          end else begin
            state_r <= IDLE;
          end
        end
        RED: begin
          rr_r    <= rr_s;
          mcand_r <= rr_s;
          zz_r    <= zz_s;
          state_r <= MUL1;
        end
        MUL1: begin
          acc_r <= step_s;
          mul_r <= {mul_r[n-2:0], 1'b0};
          if (cnt_r == LAST_BIT) begin
            cnt_r   <= '0;
            state_r <= ADDZ;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
          end
        end
        ADDZ: begin
          mcand_r <= addz_s;
          acc_r   <= '0;
          mul_r   <= kinv_r;
          state_r <= MUL2;
        end
        MUL2: begin
          acc_r <= step_s;
          mul_r <= {mul_r[n-2:0], 1'b0};
          if (cnt_r == LAST_BIT) begin
            cnt_r   <= '0;
            state_r <= CHECK;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
          end
        end
        CHECK: begin
          res_r   <= fold_s;
          state_r <= DONE;
        end
        DONE: begin
          r       <= rr_r;
          s       <= res_r;
          err     <= (rr_r == '0) | (res_r == '0);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecdsa_sign_finalize.sv
// Directed bench for ecdsa_sign_finalize at n=8, q=251.
// The expected values were worked out by hand. When ECDSA_LOW_S_EN is defined,
// the bench uses the low-S column of the table instead of the plain s column.
module tb_ecdsa_sign_finalize;

  localparam int N = 8;
  localparam logic [N-1:0] Q = 8'd251;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] x3, q, z, d, kinv;
  logic [N-1:0] r, s;
  logic         busy, done, err;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [N-1:0] x3;
    logic [N-1:0] d;
    logic [N-1:0] z;
    logic [N-1:0] kinv;
    logic [N-1:0] er;
    logic [N-1:0] es;
    logic [N-1:0] es_low;
    logic         eerr;
  } vec_t;

  vec_t vecs[10];

  ecdsa_sign_finalize #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x3(x3), .q(q), .z(z), .d(d), .kinv(kinv),
    .r(r), .s(s), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pick_s(input vec_t v);
`ifdef ECDSA_LOW_S_EN
    return v.es_low;
`else
    return v.es;
`endif
  endfunction

  task automatic set_inputs(input vec_t v);
    x3 = v.x3; d = v.d; z = v.z; kinv = v.kinv; q = Q;
  endtask

  // Raise start, let one edge sample it, then count edges until done rises.
  task automatic run_op(output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    set_inputs(v);
    run_op(lat);
    check({tag, "_latency"}, 32'(lat), 32'd20);
    check({tag, "_r"},   32'(r),   32'(v.er));
    check({tag, "_s"},   32'(s),   32'(pick_s(v)));
    check({tag, "_err"}, 32'(err), 32'(v.eerr));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_r_hold"}, 32'(r), 32'(v.er));
  endtask

  initial begin
    int first_done, second_done, pulses;
    vec_t junk;
    n_cmp = 0; n_fail = 0;
    //          x3      d       z       kinv    r       s       s_low   err
    vecs[0] = '{8'd7,   8'd5,   8'd20,  8'd3,   8'd7,   8'd165, 8'd86,  1'b0};
    vecs[1] = '{8'd251, 8'd5,   8'd20,  8'd3,   8'd0,   8'd60,  8'd60,  1'b1};
    vecs[2] = '{8'd255, 8'd5,   8'd20,  8'd3,   8'd4,   8'd120, 8'd120, 1'b0};
    vecs[3] = '{8'd7,   8'd5,   8'd216, 8'd3,   8'd7,   8'd0,   8'd0,   1'b1};
    vecs[4] = '{8'd7,   8'd5,   8'd255, 8'd3,   8'd7,   8'd117, 8'd117, 1'b0};
    vecs[5] = '{8'd100, 8'd0,   8'd50,  8'd7,   8'd100, 8'd99,  8'd99,  1'b0};
    vecs[6] = '{8'd9,   8'd10,  8'd1,   8'd0,   8'd9,   8'd0,   8'd0,   1'b1};
    vecs[7] = '{8'd200, 8'd150, 8'd100, 8'd77,  8'd200, 8'd217, 8'd34,  1'b0};
    vecs[8] = '{8'd1,   8'd1,   8'd0,   8'd1,   8'd1,   8'd1,   8'd1,   1'b0};
    vecs[9] = '{8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd0,   8'd0,   1'b1};

    reset = 1'b1; start = 1'b0;
    x3 = '0; q = Q; z = '0; d = '0; kinv = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_r", 32'(r), 32'd0);
    check("reset_s", 32'(s), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the third MUL1 cycle: the abort is asynchronous and leaves no done.
    @(negedge clk);
    set_inputs(vecs[7]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_r", 32'(r), 32'd0);
    check("abort_s", 32'(s), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    apply_vec(vecs[0], "after_abort");

    // Hold start for 40 edges and disturb the inputs while the first run is busy.
    junk = '{8'd99, 8'd44, 8'd123, 8'd200, 8'd0, 8'd0, 8'd0, 1'b0};
    @(negedge clk);
    set_inputs(vecs[0]);
    start = 1'b1;
    first_done = -1; second_done = -1; pulses = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first_done < 0) begin
          first_done = k;
          check("hold_first_r", 32'(r), 32'(vecs[0].er));
          check("hold_first_s", 32'(s), 32'(pick_s(vecs[0])));
        end else begin
          second_done = k;
          check("hold_second_r", 32'(r), 32'(vecs[0].er));
          check("hold_second_s", 32'(s), 32'(pick_s(vecs[0])));
        end
      end
      if (k == 3) set_inputs(junk);
      if (k == 18) set_inputs(vecs[0]);
      if (k == 39) start = 1'b0;
    end
    check("hold_pulses", 32'(pulses), 32'd2);
    check("hold_first_latency", 32'(first_done), 32'd20);
    check("hold_spacing", 32'(second_done - first_done), 32'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
